// File: rtl/pixel_proc_pkg.sv
// pixel_proc_pkg
// Shared definitions for the streaming pixel processor: mode encodings,
// the pixel type, the convolution accumulator width and a MAC helper.
// No ports (package).

package pixel_proc_pkg;

    localparam logic [1:0] MODE_BYPASS = 2'b00;
    localparam logic [1:0] MODE_INVERT = 2'b01;
    localparam logic [1:0] MODE_CONV   = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    typedef logic [7:0] pixel_t;

    // Nine 8x8 products peak at 9*255*255 = 585225, which fits in 20 bits.
    localparam int SUM_W = 20;

    localparam pixel_t PIX_MAX = 8'hFF;

    // One coefficient*pixel product, widened to the accumulator width so the
    // adder tree never truncates.
    function automatic logic [SUM_W-1:0] mac_term(input pixel_t coef, input pixel_t pix);
        return SUM_W'(coef) * SUM_W'(pix);
    endfunction

endpackage

// File: rtl/pixel_line_buffer.sv
// pixel_line_buffer
// IMG_WIDTH-deep, 8-bit delay line. Every enabled clock shifts one pixel in,
// so dout is the pixel that entered exactly IMG_WIDTH shifts ago, i.e. the
// same column of the previous line when shifted once per accepted pixel.
// Contents are not reset; stale data is never used before it is refilled.
// Ports:
//   clk       processing clock
//   shift_en  advance the delay line by one pixel
//   din       pixel entering the line
//   dout      pixel leaving the line (IMG_WIDTH shifts old)

module pixel_line_buffer
    import pixel_proc_pkg::*;
#(
    parameter int IMG_WIDTH = 32
) (
    input  logic   clk,
    input  logic   shift_en,
    input  pixel_t din,
    output pixel_t dout
);

    pixel_t taps [IMG_WIDTH];

    // Plain shift chain; taps[IMG_WIDTH-1] is the oldest entry.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            taps[0] <= din;
            for (int i = 1; i < IMG_WIDTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign dout = taps[IMG_WIDTH-1];

endmodule

// File: rtl/pixel_proc_core.sv
// pixel_proc_core
// Streaming 8-bit pixel processor: bypass, invert or 3x3 convolution over a
// raster frame, one output pixel per accepted input pixel, 1-cycle latency.
// Optional feature macro: PIX_PROC_THRESHOLD_EN -- when defined, mode 11 is a
// binary threshold (in >= 128 ? 255 : 0); otherwise mode 11 is bypass.
// Ports:
//   clk, rst   processing clock, asynchronous active-high reset
//   pixel_in   input pixel (FWFT FIFO data), valid_in / ready_out handshake
//   mode       00 bypass, 01 invert, 10 convolution, 11 reserved/threshold
//   kernel     nine 8-bit coefficients, [7:0]=top-left .. [71:64]=bottom-right
//   pixel_out  processed pixel, valid_out / ready_in handshake
//   status     high while a frame is in progress

module pixel_proc_core
    import pixel_proc_pkg::*;
#(
    parameter int IMG_WIDTH    = 32,
    parameter int IMG_HEIGHT   = 32,
    parameter int KERNEL_SHIFT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  pixel_t      pixel_in,
    input  logic        valid_in,
    output logic        ready_out,
    input  logic [1:0]  mode,
    input  logic [71:0] kernel,
    output pixel_t      pixel_out,
    output logic        valid_out,
    input  logic        ready_in,
    output logic        status
);

    localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             accept;
    logic             last_pixel;
    logic             first_pixel;

    // Line-buffer outputs: same column one and two lines above.
    pixel_t mid_line;
    pixel_t top_line;

    // Two-deep history per window row (d1 = one column left, d2 = two left).
    pixel_t top_d1, top_d2;
    pixel_t mid_d1, mid_d2;
    pixel_t bot_d1, bot_d2;

    pixel_t              win [9];
    logic [SUM_W-1:0]    sum;
    logic [SUM_W-1:0]    shifted;
    logic                window_ok;
    pixel_t              conv_pix;
    pixel_t              result;

    // Single output register, no skid: a new pixel can enter whenever the
    // register is empty or is being drained this cycle.
    assign ready_out   = !valid_out || ready_in;
    assign accept      = valid_in && ready_out;
    assign last_pixel  = (col == COL_LAST) && (row == ROW_LAST);
    assign first_pixel = (col == '0) && (row == '0);

    pixel_line_buffer #(.IMG_WIDTH(IMG_WIDTH)) u_line_mid (
        .clk      (clk),
        .shift_en (accept),
        .din      (pixel_in),
        .dout     (mid_line)
    );

    pixel_line_buffer #(.IMG_WIDTH(IMG_WIDTH)) u_line_top (
        .clk      (clk),
        .shift_en (accept),
        .din      (mid_line),
        .dout     (top_line)
    );

    // Assemble the 3x3 window ending at the current pixel, row-major from the
    // top-left, and run the MAC tree plus shift/saturate.
    always_comb begin
        win[0] = top_d2;
        win[1] = top_d1;
        win[2] = top_line;
        win[3] = mid_d2;
        win[4] = mid_d1;
        win[5] = mid_line;
        win[6] = bot_d2;
        win[7] = bot_d1;
        win[8] = pixel_in;
        sum = '0;
        for (int i = 0; i < 9; i++) begin
            sum = sum + mac_term(kernel[8*i +: 8], win[i]);
        end
        shifted   = sum >> KERNEL_SHIFT;
        window_ok = (row >= ROW_W'(2)) && (col >= COL_W'(2));
        if (!window_ok) begin
            conv_pix = '0;
        end else if (shifted > SUM_W'(PIX_MAX)) begin
            conv_pix = PIX_MAX;
        end else begin
            conv_pix = shifted[7:0];
        end
    end

    // Per-pixel mode select; mode is only meaningful on an accept.
    always_comb begin
        result = pixel_in;
        case (mode)
            MODE_INVERT: result = PIX_MAX - pixel_in;
            MODE_CONV:   result = conv_pix;
`ifdef PIX_PROC_THRESHOLD_EN
            MODE_RSVD:   result = (pixel_in >= 8'd128) ? PIX_MAX : '0;
`endif
            default:     result = pixel_in;
        endcase
    end

    // Output register, window history, raster counters and frame status.
    // History and counters advance on every accept regardless of mode so a
    // switch into convolution sees valid neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_out <= '0;
            valid_out <= 1'b0;
            status    <= 1'b0;
            col       <= '0;
            row       <= '0;
            top_d1    <= '0;
            top_d2    <= '0;
            mid_d1    <= '0;
            mid_d2    <= '0;
            bot_d1    <= '0;
            bot_d2    <= '0;
        end else begin
            if (accept) begin
                pixel_out <= result;
                valid_out <= 1'b1;
                top_d1    <= top_line;
                top_d2    <= top_d1;
                mid_d1    <= mid_line;
                mid_d2    <= mid_d1;
                bot_d1    <= pixel_in;
                bot_d2    <= bot_d1;
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                if (last_pixel) begin
                    status <= 1'b0;
                end else if (first_pixel) begin
                    status <= 1'b1;
                end
            end else if (ready_in) begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pixel_proc_core.sv
// tb_pixel_proc_core
// Self-checking bench for pixel_proc_core: a table of hand-computed
// bypass/invert/reserved vectors, then whole frames checked against a small
// frame-memory reference model, plus backpressure and mid-frame reset
// sequences. Inputs change just after the falling edge; outputs are checked
// at the next falling edge.

module tb_pixel_proc_core;
    import pixel_proc_pkg::*;

    localparam int W = 32;
    localparam int H = 32;

    logic        clk = 1'b0;
    logic        rst;
    pixel_t      pixel_in;
    logic        valid_in;
    logic        ready_out;
    logic [1:0]  mode;
    logic [71:0] kernel;
    pixel_t      pixel_out;
    logic        valid_out;
    logic        ready_in;
    logic        status;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: pixels of the current frame and raster position.
    pixel_t frame_mem [H][W];
    int     mrow = 0;
    int     mcol = 0;
    logic   exp_status = 1'b0;

    typedef struct {
        logic [1:0] m;
        pixel_t     pix;
        pixel_t     exp;
    } vec_t;

    vec_t vecs [20];

    always #5 clk = ~clk;

    pixel_proc_core #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL_SHIFT(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .pixel_in  (pixel_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .mode      (mode),
        .kernel    (kernel),
        .pixel_out (pixel_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .status    (status)
    );

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input pixel_t p, input logic [1:0] m);
        pixel_in = p;
        mode     = m;
        valid_in = 1'b1;
        ready_in = 1'b1;
    endtask

    // Expected output for the pixel just stored at (mrow, mcol).
    function automatic pixel_t model_result(input logic [1:0] m, input pixel_t p);
        int sum;
        case (m)
            MODE_BYPASS: return p;
            MODE_INVERT: return 8'hFF - p;
            MODE_CONV: begin
                if (mrow < 2 || mcol < 2) return 8'h00;
                sum = 0;
                for (int dr = 0; dr < 3; dr++) begin
                    for (int dc = 0; dc < 3; dc++) begin
                        sum += int'(kernel[8*(dr*3+dc) +: 8]) * int'(frame_mem[mrow-2+dr][mcol-2+dc]);
                    end
                end
                sum = sum >> 3;
                return (sum > 255) ? 8'hFF : pixel_t'(sum);
            end
            default: begin
`ifdef PIX_PROC_THRESHOLD_EN
                return (p >= 8'd128) ? 8'hFF : 8'h00;
`else
                return p;
`endif
            end
        endcase
    endfunction

    task automatic model_accept(input pixel_t p, input logic [1:0] m, output pixel_t exp);
        frame_mem[mrow][mcol] = p;
        exp = model_result(m, p);
        if (mrow == H-1 && mcol == W-1) exp_status = 1'b0;
        else if (mrow == 0 && mcol == 0) exp_status = 1'b1;
        if (mcol == W-1) begin
            mcol = 0;
            mrow = (mrow == H-1) ? 0 : mrow + 1;
        end else begin
            mcol++;
        end
    endtask

    // One accepted pixel with ready_in high, checked one cycle later.
    task automatic accept_and_check(input pixel_t p, input logic [1:0] m, input string tag);
        pixel_t exp;
        applyStimulus(p, m);
        model_accept(p, m, exp);
        @(negedge clk);
        checkOutput({tag, "_pix"}, pixel_out, exp);
        checkOutput({tag, "_valid"}, {7'b0, valid_out}, 8'h01);
        checkOutput({tag, "_status"}, {7'b0, status}, {7'b0, exp_status});
    endtask

    // Stall the output for five cycles with a pixel waiting at the input.
    task automatic backpressure(input pixel_t waiting, input pixel_t held_exp);
        pixel_in = waiting;
        mode     = MODE_BYPASS;
        valid_in = 1'b1;
        ready_in = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checkOutput($sformatf("bp_ready_out[%0d]", c), {7'b0, ready_out}, 8'h00);
            @(negedge clk);
            checkOutput($sformatf("bp_hold_pix[%0d]", c), pixel_out, held_exp);
            checkOutput($sformatf("bp_hold_valid[%0d]", c), {7'b0, valid_out}, 8'h01);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        pixel_t dummy;
        int     k;

        for (int i = 0; i < 16; i++) vecs[i] = '{MODE_BYPASS, pixel_t'(i), pixel_t'(i)};
        vecs[16] = '{MODE_INVERT, 8'h05, 8'hFA};
        vecs[17] = '{MODE_INVERT, 8'h80, 8'h7F};
        vecs[18] = '{MODE_INVERT, 8'hFF, 8'h00};
`ifdef PIX_PROC_THRESHOLD_EN
        vecs[19] = '{MODE_RSVD, 8'hC8, 8'hFF};
`else
        vecs[19] = '{MODE_RSVD, 8'hC8, 8'hC8};
`endif

        rst      = 1'b1;
        valid_in = 1'b0;
        ready_in = 1'b1;
        mode     = MODE_BYPASS;
        pixel_in = 8'h00;
        kernel   = {9{8'h01}};
        repeat (2) @(negedge clk);
        checkOutput("reset_pix", pixel_out, 8'h00);
        checkOutput("reset_valid", {7'b0, valid_out}, 8'h00);
        checkOutput("reset_status", {7'b0, status}, 8'h00);
        checkOutput("reset_ready_out", {7'b0, ready_out}, 8'h01);
        rst = 1'b0;

        $display("[TB] table vectors: bypass, invert, reserved");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].pix, vecs[i].m);
            model_accept(vecs[i].pix, vecs[i].m, dummy);
            @(negedge clk);
            checkOutput($sformatf("vec[%0d]_pix", i), pixel_out, vecs[i].exp);
            checkOutput($sformatf("vec[%0d]_valid", i), {7'b0, valid_out}, 8'h01);
            checkOutput($sformatf("vec[%0d]_status", i), {7'b0, status}, 8'h01);
        end

        valid_in = 1'b0;
        @(negedge clk);
        checkOutput("idle_valid_clear", {7'b0, valid_out}, 8'h00);
        checkOutput("idle_status_held", {7'b0, status}, 8'h01);
        ready_in = 1'b0;
        #1;
        checkOutput("idle_ready_out", {7'b0, ready_out}, 8'h01);
        @(negedge clk);

        $display("[TB] completing first frame in bypass");
        k = 20;
        while (!(mrow == 0 && mcol == 0)) begin
            accept_and_check(pixel_t'(k), MODE_BYPASS, $sformatf("fill[%0d]", k));
            k++;
        end
        checkOutput("frame1_end_status", {7'b0, status}, 8'h00);

        $display("[TB] convolution, constant 0x0A frame");
        for (int i = 0; i < W*H; i++) begin
            accept_and_check(8'h0A, MODE_CONV, $sformatf("conv0A[%0d]", i));
            if (i == 33) checkOutput("conv0A_r1c1", pixel_out, 8'h00);
            if (i == 65) checkOutput("conv0A_r2c1", pixel_out, 8'h00);
            if (i == 66) checkOutput("conv0A_r2c2", pixel_out, 8'h0B);
        end

        $display("[TB] convolution, constant 0xFF frame");
        for (int i = 0; i < W*H; i++) begin
            accept_and_check(8'hFF, MODE_CONV, $sformatf("convFF[%0d]", i));
            if (i == 0) checkOutput("convFF_r0c0", pixel_out, 8'h00);
            if (i == 100) checkOutput("convFF_r3c4_sat", pixel_out, 8'hFF);
        end

        $display("[TB] ramp frame with backpressure");
        for (int i = 0; i < W*H; i++) begin
            if (i == 10) backpressure(pixel_t'(i), pixel_t'(i - 1));
            accept_and_check(pixel_t'(i % 256), MODE_BYPASS, $sformatf("ramp[%0d]", i));
            if (i == 0) checkOutput("ramp_status_rise", {7'b0, status}, 8'h01);
        end
        checkOutput("ramp_status_fall", {7'b0, status}, 8'h00);
        accept_and_check(8'h77, MODE_CONV, "newframe_conv");
        checkOutput("newframe_conv_zero", pixel_out, 8'h00);

        $display("[TB] asynchronous reset mid-frame");
        k = 1;
        while ((mrow * W + mcol) < 500) begin
            accept_and_check(pixel_t'(k), MODE_BYPASS, $sformatf("pre_rst[%0d]", k));
            k++;
        end
        checkOutput("pre_rst_status", {7'b0, status}, 8'h01);
        valid_in = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        checkOutput("rst_async_valid", {7'b0, valid_out}, 8'h00);
        checkOutput("rst_async_status", {7'b0, status}, 8'h00);
        checkOutput("rst_async_pix", pixel_out, 8'h00);
        @(negedge clk);
        rst        = 1'b0;
        mrow       = 0;
        mcol       = 0;
        exp_status = 1'b0;

        $display("[TB] post-reset frame, graded kernel, mode switching");
        kernel = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        for (int i = 0; i < W*H; i++) begin
            logic [1:0] m;
            m = (i >= 64 && i < 128) ? MODE_INVERT : MODE_CONV;
            accept_and_check(pixel_t'((i * 5) % 32), m, $sformatf("post_rst[%0d]", i));
            if (i == 33) checkOutput("post_rst_r1c1_zero", pixel_out, 8'h00);
            if (i == 63) checkOutput("post_rst_r1c31_zero", pixel_out, 8'h00);
        end
        checkOutput("post_rst_status_end", {7'b0, status}, 8'h00);

        valid_in = 1'b0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
